// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared network sizes, write-select encoding and loader states
package nn_pkg;

   localparam int N_IN  = 784;
   localparam int N_HID = 32;
   localparam int N_OUT = 10;

   localparam int W1_SIZE = N_IN * N_HID;
   localparam int B1_SIZE = N_HID;
   localparam int W2_SIZE = N_HID * N_OUT;
   localparam int B2_SIZE = N_OUT;

   localparam int ADDR_W = 15;

   localparam logic [1:0] SEL_W1 = 2'd0;
   localparam logic [1:0] SEL_B1 = 2'd1;
   localparam logic [1:0] SEL_W2 = 2'd2;
   localparam logic [1:0] SEL_B2 = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W1,
      ST_B1,
      ST_W2,
      ST_B2,
      ST_CHK,
      ST_DONE
   } loader_state_t;

endpackage

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - byte-stream writer for W1/B1/W2/B2 with trailing XOR checksum
module weight_loader #(
   parameter int N_IN  = nn_pkg::N_IN,
   parameter int N_HID = nn_pkg::N_HID,
   parameter int N_OUT = nn_pkg::N_OUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [1:0]  wr_sel,
   output logic [14:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy,
   output logic        done,
   output logic        chk_err
);
   import nn_pkg::*;

   localparam logic [14:0] W1_LAST = 15'(N_IN * N_HID - 1);
   localparam logic [14:0] B1_LAST = 15'(N_HID - 1);
   localparam logic [14:0] W2_LAST = 15'(N_HID * N_OUT - 1);
   localparam logic [14:0] B2_LAST = 15'(N_OUT - 1);

   loader_state_t state, state_nxt;
   logic [14:0]   addr;
   logic [7:0]    xor_acc;
   logic [1:0]    sel_cur;
   logic          region_last;
   logic          accept;
   logic          start_ok;

   assign accept   = in_valid && in_ready;
   assign start_ok = load_start && (state == ST_IDLE || state == ST_DONE);
   assign done     = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // in_ready depends only on the registered state, never on in_valid
   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      sel_cur     = SEL_W1;
      region_last = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (load_start) state_nxt = ST_W1;
         end
         ST_W1: begin
            in_ready    = 1'b1;
            busy        = 1'b1;
            sel_cur     = SEL_W1;
            region_last = (addr == W1_LAST);
            if (in_valid && region_last) state_nxt = ST_B1;
         end
         ST_B1: begin
            in_ready    = 1'b1;
            busy        = 1'b1;
            sel_cur     = SEL_B1;
            region_last = (addr == B1_LAST);
            if (in_valid && region_last) state_nxt = ST_W2;
         end
         ST_W2: begin
            in_ready    = 1'b1;
            busy        = 1'b1;
            sel_cur     = SEL_W2;
            region_last = (addr == W2_LAST);
            if (in_valid && region_last) state_nxt = ST_B2;
         end
         ST_B2: begin
            in_ready    = 1'b1;
            busy        = 1'b1;
            sel_cur     = SEL_B2;
            region_last = (addr == B2_LAST);
            if (in_valid && region_last) state_nxt = ST_CHK;
         end
         ST_CHK: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Registered write port; the address wraps to 0 on the same edge the region changes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr    <= '0;
         xor_acc <= '0;
         wr_en   <= 1'b0;
         wr_sel  <= SEL_W1;
         wr_addr <= '0;
         wr_data <= '0;
         chk_err <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (start_ok) begin
            addr    <= '0;
            xor_acc <= '0;
            chk_err <= 1'b0;
         end else if (accept) begin
            if (state == ST_CHK) begin
               chk_err <= (in_data != xor_acc);
            end else begin
               wr_en   <= 1'b1;
               wr_sel  <= sel_cur;
               wr_addr <= addr;
               wr_data <= in_data;
               xor_acc <= xor_acc ^ in_data;
               addr    <= region_last ? 15'd0 : addr + 15'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - self-checking bench for weight_loader
module tb_weight_loader;
   import nn_pkg::*;

   localparam int TOTAL = W1_SIZE + B1_SIZE + W2_SIZE + B2_SIZE;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        wr_en;
   logic [1:0]  wr_sel;
   logic [14:0] wr_addr;
   logic [7:0]  wr_data;
   logic        busy;
   logic        done;
   logic        chk_err;

   weight_loader dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_sel     (wr_sel),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .chk_err    (chk_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  sel;
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      logic        ls;
      logic        v;
      logic [7:0]  d;
      logic        rdy;
      logic        wen;
      logic [14:0] addr;
      logic [7:0]  data;
      logic        bsy;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   wr_t  exp_q[$];
   logic [7:0] img [TOTAL];
   bit         wflag [TOTAL];
   logic [7:0] ref_img [TOTAL];
   bit   sb_en = 0;
   bit   nogap_run = 0;
   int   cyc = 0;
   int   wr_count = 0;
   int   first_wr = -1;
   int   last_wr = -1;
   int   done_rises = 0;
   logic done_q = 1'b0;
   bit   prev_wen = 0;
   wr_t  prev_wr = '0;
   wr_t  last_rec = '0;
   wr_t  got;
   int   widx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic wr_t expect_of(input int i);
      wr_t e;
      int  a;
      if (i < W1_SIZE) begin
         e.sel = SEL_W1; a = i;
      end else if (i < W1_SIZE + B1_SIZE) begin
         e.sel = SEL_B1; a = i - W1_SIZE;
      end else if (i < W1_SIZE + B1_SIZE + W2_SIZE) begin
         e.sel = SEL_W2; a = i - W1_SIZE - B1_SIZE;
      end else begin
         e.sel = SEL_B2; a = i - W1_SIZE - B1_SIZE - W2_SIZE;
      end
      e.addr = 15'(a);
      e.data = 8'(a);
      return e;
   endfunction

   function automatic int base_of(input logic [1:0] sel);
      case (sel)
         2'd0:    return 0;
         2'd1:    return W1_SIZE;
         2'd2:    return W1_SIZE + B1_SIZE;
         default: return W1_SIZE + B1_SIZE + W2_SIZE;
      endcase
   endfunction

   always @(posedge clk) cyc++;

   // Scoreboard monitor: every registered write must match the oldest accepted byte
   always @(negedge clk) begin
      if (done && !done_q) done_rises++;
      done_q = done;
      if (sb_en) begin
         got = {wr_sel, wr_addr, wr_data};
         if (wr_en) begin
            wr_count++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write actual=0x%0h required=none", got);
            end else begin
               check("write", got, exp_q.pop_front());
            end
            widx = base_of(wr_sel) + int'(wr_addr);
            if (widx < TOTAL) begin
               img[widx] = wr_data;
               wflag[widx] = 1;
            end
            if (nogap_run && wr_sel == SEL_B1 && wr_addr == 15'd0)
               check("w1_b1_boundary", {prev_wen, prev_wr}, {1'b1, SEL_W1, 15'(W1_SIZE - 1), 8'hFF});
            last_rec = got;
         end else if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL missing_write actual=none required=0x%0h", exp_q[0]);
            void'(exp_q.pop_front());
         end
         prev_wen = wr_en;
         prev_wr  = got;
      end
   end

   task automatic drive_byte(input logic [7:0] d, input bit gaps, input bit ls, output bit ok);
      int tries = 0;
      ok = 0;
      while (tries < 64) begin
         @(negedge clk);
         load_start = ls && (tries == 0);
         in_valid   = gaps ? ($urandom_range(0, 4) < 3) : 1'b1;
         in_data    = d;
         #4;
         if (in_valid && in_ready) begin
            ok = 1;
            return;
         end
         tries++;
      end
      checks++; errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
   endtask

   task automatic start_load();
      @(negedge clk);
      load_start = 1'b1;
      in_valid   = 1'b0;
      @(negedge clk);
      load_start = 1'b0;
      #1;
      check("start_state", {in_ready, busy, done, chk_err}, 4'b1100);
   endtask

   task automatic clear_image();
      for (int k = 0; k < TOTAL; k++) begin
         img[k] = 8'h00;
         wflag[k] = 0;
      end
   endtask

   task automatic full_load(input bit gaps, input bit bad_chk, input int ls_at);
      logic [7:0] x = 8'h00;
      bit         ok;
      wr_t        e;
      for (int i = 0; i < TOTAL; i++) begin
         e = expect_of(i);
         drive_byte(e.data, gaps, i == ls_at, ok);
         if (!ok) return;
         exp_q.push_back(e);
         x ^= e.data;
      end
      drive_byte(bad_chk ? (x ^ 8'h01) : x, gaps, 1'b0, ok);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("done_after_chk", {in_ready, busy, done, chk_err}, {3'b001, bad_chk});
   endtask

   function automatic int image_errors(input bit against_ref);
      int n = 0;
      wr_t e;
      for (int k = 0; k < TOTAL; k++) begin
         e = expect_of(k);
         if (!wflag[k]) n++;
         else if (against_ref ? (img[k] !== ref_img[k]) : (img[k] !== e.data)) n++;
      end
      return n;
   endfunction

   vec_t vecs [7];
   bit   ok1;
   int   rises0;

   initial begin
      vecs[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 15'd0, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 15'd0, 8'h00, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 15'd0, 8'h22, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 15'd0, 8'h00, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 15'd1, 8'h33, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 15'd2, 8'h44, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 15'd0, 8'h00, 1'b1};

      repeat (3) @(negedge clk);
      check("reset_state", {in_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, chk_err}, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 7; i++) begin
         load_start = vecs[i].ls;
         in_valid   = vecs[i].v;
         in_data    = vecs[i].d;
         @(negedge clk);
         check($sformatf("vec%0d_ctrl", i), {in_ready, wr_en, busy, done}, {vecs[i].rdy, vecs[i].wen, vecs[i].bsy, 1'b0});
         if (vecs[i].wen)
            check($sformatf("vec%0d_wr", i), {wr_sel, wr_addr, wr_data}, {SEL_W1, vecs[i].addr, vecs[i].data});
      end
      load_start = 1'b0;
      in_valid   = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      sb_en = 1;

      start_load();
      for (int i = 0; i < 1000; i++) begin
         drive_byte(expect_of(i).data, 1'b0, 1'b0, ok1);
         if (ok1) exp_q.push_back(expect_of(i));
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1 rst = 1'b0;
      #1 check("midload_reset", {in_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, chk_err}, 32'd0);
      @(negedge clk);
      #1 check("midload_reset_next", {in_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, chk_err}, 32'd0);
      check("queue_after_reset", exp_q.size(), 0);
      exp_q.delete();
      rst = 1'b1;

      clear_image();
      wr_count = 0; first_wr = -1; last_wr = -1;
      nogap_run = 1;
      start_load();
      full_load(1'b0, 1'b0, -1);
      nogap_run = 0;
      check("write_count", wr_count, TOTAL);
      check("no_bubble_span", last_wr - first_wr, TOTAL - 1);
      check("last_write", last_rec, {SEL_B2, 15'd9, 8'h09});
      check("image_nogap", image_errors(1'b0), 0);
      for (int k = 0; k < TOTAL; k++) ref_img[k] = img[k];

      @(negedge clk);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      #1 check("done_hold", {in_ready, busy, done, chk_err}, 4'b0010);

      clear_image();
      wr_count = 0;
      rises0 = done_rises;
      start_load();
      full_load(1'b1, 1'b1, W1_SIZE + B1_SIZE + 100);
      check("gap_write_count", wr_count, TOTAL);
      check("gap_image", image_errors(1'b1), 0);
      check("one_done_per_load", done_rises - rises0, 1);

      start_load();
      drive_byte(8'hA5, 1'b0, 1'b0, ok1);
      if (ok1) exp_q.push_back({SEL_W1, 15'd0, 8'hA5});
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("restart_queue_empty", exp_q.size(), 0);
      check("restart_last", last_rec, {SEL_W1, 15'd0, 8'hA5});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
